// File: rtl/comparator_seq_n_if.sv
// Request/result bundle for the sequential magnitude comparator.
// The master side drives the operands and start; the slave side reports status and the result.
interface comparator_seq_n_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             greater;
   logic             less;
   logic             equal;

   modport master (
      output start, a, b, signed_mode,
      input  busy, done, greater, less, equal
   );

   modport slave (
      input  start, a, b, signed_mode,
      output busy, done, greater, less, equal
   );
endinterface

// File: rtl/comparator_seq_n.sv
// Multi-cycle magnitude comparator. It walks CHUNK-bit slices from the MSB end
// and stops at the first slice that differs.
module comparator_seq_n #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input logic                clk,
   input logic                rst_n,
   comparator_seq_n_if.slave  cmp
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [IDX_W-1:0] idx;
   logic             greater_q;
   logic             less_q;
   logic             equal_q;
   logic             done_q;
   logic             busy_c;
   logic             slice_gt;
   logic             slice_lt;
   logic             last_slice;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (cmp.start) state_next = RUN;
         RUN:  if (slice_gt || slice_lt || last_slice) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The operands are shifted left once per equal slice, so the current slice is always the top CHUNK bits.
   always_comb begin
      busy_c     = (state == RUN);
      slice_gt   = op_a[WIDTH-1 -: CHUNK] > op_b[WIDTH-1 -: CHUNK];
      slice_lt   = op_a[WIDTH-1 -: CHUNK] < op_b[WIDTH-1 -: CHUNK];
      last_slice = (idx == IDX_W'(NCHUNK - 1));
   end

   // Flipping the sign bit turns the two's-complement order into the unsigned order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         idx       <= '0;
         greater_q <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (cmp.start) begin
               op_a <= cmp.signed_mode ? (cmp.a ^ MSB_MASK) : cmp.a;
               op_b <= cmp.signed_mode ? (cmp.b ^ MSB_MASK) : cmp.b;
               idx  <= '0;
            end
         end else begin
            if (slice_gt) begin
               greater_q <= 1'b1;
               less_q    <= 1'b0;
               equal_q   <= 1'b0;
               done_q    <= 1'b1;
            end else if (slice_lt) begin
               greater_q <= 1'b0;
               less_q    <= 1'b1;
               equal_q   <= 1'b0;
               done_q    <= 1'b1;
            end else if (last_slice) begin
               greater_q <= 1'b0;
               less_q    <= 1'b0;
               equal_q   <= 1'b1;
               done_q    <= 1'b1;
            end else begin
               idx  <= idx + IDX_W'(1);
               op_a <= op_a << CHUNK;
               op_b <= op_b << CHUNK;
            end
         end
      end
   end

   assign cmp.busy    = busy_c;
   assign cmp.done    = done_q;
   assign cmp.greater = greater_q;
   assign cmp.less    = less_q;
   assign cmp.equal   = equal_q;
endmodule

// File: tb/tb_comparator_seq_n.sv
// Directed bench for comparator_seq_n: a 64/8 instance and a 12/4 instance
// share the clock and reset.
module tb_comparator_seq_n;
   logic clk;
   logic rst_n;
   logic sel;
   int   compared;
   int   mismatched;
   logic [2:0] last_res;

   comparator_seq_n_if #(.WIDTH(64)) cif   ();
   comparator_seq_n_if #(.WIDTH(12)) cif12 ();

   comparator_seq_n #(.WIDTH(64), .CHUNK(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cmp   (cif)
   );

   comparator_seq_n #(.WIDTH(12), .CHUNK(4)) dut12 (
      .clk   (clk),
      .rst_n (rst_n),
      .cmp   (cif12)
   );

   logic       obs_busy;
   logic       obs_done;
   logic [2:0] obs_res;
   assign obs_busy = sel ? cif12.busy : cif.busy;
   assign obs_done = sel ? cif12.done : cif.done;
   assign obs_res  = sel ? {cif12.greater, cif12.less, cif12.equal}
                         : {cif.greater, cif.less, cif.equal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives a request on the selected bus from a negedge and scrambles the inputs once it is accepted.
   // The task returns at the negedge of the done cycle. pulse_at > 0 raises start again so that it
   // reaches the DUT at that edge while RUN is active.
   task automatic applyStimulus(input bit s, input logic [63:0] av, input logic [63:0] bv, input bit sm,
                                input int exp_lat, input logic [2:0] exp_res, input int pulse_at,
                                input string tag);
      int edges;
      sel = s;
      if (s) begin
         cif12.a = av[11:0]; cif12.b = bv[11:0]; cif12.signed_mode = sm; cif12.start = 1'b1;
      end else begin
         cif.a = av; cif.b = bv; cif.signed_mode = sm; cif.start = 1'b1;
      end
      @(negedge clk);
      cif.start   = 1'b0;
      cif12.start = 1'b0;
      cif.a   = ~av;        cif.b   = ~bv;        cif.signed_mode   = ~sm;
      cif12.a = ~av[11:0];  cif12.b = ~bv[11:0];  cif12.signed_mode = ~sm;
      checkOutput({tag, " busy_after_accept"}, 64'(obs_busy), 64'(1));
      edges = 0;
      while (!obs_done && edges < 20) begin
         checkOutput({tag, " result_hold"}, 64'(obs_res), 64'(last_res));
         if (edges == pulse_at - 1) begin
            if (s) begin cif12.start = 1'b1; cif12.a = '1; cif12.b = '0; end
            else   begin cif.start   = 1'b1; cif.a   = '1; cif.b   = '0; end
         end else begin
            cif.start   = 1'b0;
            cif12.start = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      cif.start   = 1'b0;
      cif12.start = 1'b0;
      checkOutput({tag, " latency"}, 64'(edges), 64'(exp_lat));
      checkOutput({tag, " done"},    64'(obs_done), 64'(1));
      checkOutput({tag, " busy_at_done"}, 64'(obs_busy), 64'(0));
      checkOutput({tag, " result"},  64'(obs_res), 64'(exp_res));
      last_res = exp_res;
   endtask

   initial begin
      int  edges;
      bit  saw_activity;
      compared   = 0;
      mismatched = 0;
      sel        = 1'b0;
      last_res   = 3'b000;
      rst_n      = 1'b0;
      cif.start   = 1'b0; cif.a   = '0; cif.b   = '0; cif.signed_mode   = 1'b0;
      cif12.start = 1'b0; cif12.a = '0; cif12.b = '0; cif12.signed_mode = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset busy",   64'(cif.busy), 64'(0));
      checkOutput("reset done",   64'(cif.done), 64'(0));
      checkOutput("reset result", 64'({cif.greater, cif.less, cif.equal}), 64'(0));
      checkOutput("reset result12", 64'({cif12.greater, cif12.less, cif12.equal}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // result bits are {greater, less, equal}
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 8, 3'b001, 0, "all_zero");
      @(negedge clk);
      applyStimulus(1'b0, 64'hBBAB_173D_F27A_C81E, 64'hFE7D_2BA2_32A8_82AA, 1'b0, 1, 3'b010, 0, "early_exit");
      @(negedge clk);
      applyStimulus(1'b0, 64'hCA7A_CC92_BA92_A22B, 64'h7EE8_223D_AEB2_383B, 1'b0, 1, 3'b100, 0, "mode_unsigned");
      @(negedge clk);
      applyStimulus(1'b0, 64'hCA7A_CC92_BA92_A22B, 64'h7EE8_223D_AEB2_383B, 1'b1, 1, 3'b010, 0, "mode_signed");
      @(negedge clk);
      applyStimulus(1'b0, 64'h2, 64'h1, 1'b0, 8, 3'b100, 0, "last_slice");
      applyStimulus(1'b0, 64'hDDFE_D8D9_992D_A8C2, 64'hDDFE_D8D9_992D_A8C2, 1'b0, 8, 3'b001, 0, "back_to_back");
      @(negedge clk);
      applyStimulus(1'b0, 64'h1000_0000_0000_0000, 64'h1000_0000_0000_0001, 1'b0, 8, 3'b010, 3, "ignored_start");
      @(negedge clk);

      // A comparison that is still running when reset arrives must leave no trace.
      sel = 1'b0;
      cif.a = '0; cif.b = '0; cif.signed_mode = 1'b0; cif.start = 1'b1;
      @(negedge clk);
      cif.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy",   64'(cif.busy), 64'(0));
      checkOutput("abort done",   64'(cif.done), 64'(0));
      checkOutput("abort result", 64'({cif.greater, cif.less, cif.equal}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      saw_activity = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (cif.done || cif.busy) saw_activity = 1'b1;
      end
      checkOutput("abort no_done", 64'(saw_activity), 64'(0));
      last_res = 3'b000;

      applyStimulus(1'b1, 64'h800, 64'h7FF, 1'b1, 1, 3'b010, 0, "alt_signed");
      @(negedge clk);
      applyStimulus(1'b1, 64'hFFF, 64'hFFF, 1'b1, 3, 3'b001, 0, "alt_equal");
      @(negedge clk);

      edges = compared;
      $display("[TB] %0d checks issued", edges);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
